ram_port_scheduler: RTL and testbench
=====================================

Name: ram_port_scheduler

Overview:
- Owns the single data RAM port (13-bit address, 64-bit data) and sequences access across the run: load, then solve, then unload.
- Three requesters share the port:
  - the IO decoder/receiver, write-only, one-cycle strobes, no backpressure;
  - the ODE solver core, read/write;
  - the output encoder, read-only.
- A mode FSM decides which requesters may own the port. In SOLVE, the solver and output encoder are arbitrated round-robin.

Parameters:
- ADDRESS_WIDTH, 13, RAM address width
- DATA_WIDTH, 64, RAM word width

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- Loading_Enable  in  1  start of a load phase (level)
- Done_Loading  in  1  decoder finished all rows
- Solve_Done  in  1  one-cycle pulse from solver
- Unload_Done  in  1  one-cycle pulse from output encoder
- LD_WE  in  1  decoder write strobe (the decoder's Done_Element)
- LD_Address  in  ADDRESS_WIDTH  decoder write address
- LD_Data  in  DATA_WIDTH  decoder write data
- SV_Req  in  1  solver request
- SV_WE  in  1  1 = write, 0 = read
- SV_Address  in  ADDRESS_WIDTH  solver address
- SV_WData  in  DATA_WIDTH  solver write data
- SV_Gnt  out  1  solver request accepted this cycle
- SV_RValid  out  1  solver read data valid
- SV_RData  out  DATA_WIDTH  solver read data
- OUT_Req  in  1  encoder read request
- OUT_Address  in  ADDRESS_WIDTH  encoder address
- OUT_Gnt  out  1  encoder request accepted this cycle
- OUT_RValid  out  1  encoder read data valid
- OUT_RData  out  DATA_WIDTH  encoder read data
- RAM_En  out  1  RAM access enable
- RAM_WE  out  1  RAM write enable
- RAM_Address  out  ADDRESS_WIDTH  RAM address
- RAM_WData  out  DATA_WIDTH  RAM write data
- RAM_RData  in  DATA_WIDTH  RAM read data (valid 1 cycle after read command)
- Mode  out  2  0 IDLE, 1 LOAD, 2 SOLVE, 3 UNLOAD
- LD_Overrun  out  1  sticky: LD_WE seen outside LOAD

Behaviour:

Reset (RST high at a clock edge):
- Mode=IDLE.
- All Gnt, RValid, RAM_En, RAM_WE and LD_Overrun = 0.
- RAM_Address, RAM_WData, SV_RData, OUT_RData = 0.
- Round-robin pointer points to the solver.
- The read-return pipeline is flushed; in-flight reads never assert RValid.
- Reset mid-operation has the same effect; no partial write is issued after the reset edge.

Mode FSM (registered, transitions on the clock edge):
- IDLE -> LOAD when Loading_Enable=1.
- LOAD -> SOLVE when Done_Loading=1.
  - An LD_WE in that same cycle is still written.
- SOLVE -> UNLOAD on Solve_Done.
- UNLOAD -> IDLE on Unload_Done.
- Completion pulses seen in other modes are ignored.

Grant (combinational from the current Mode and requests, one grant per cycle):
- LOAD: only the loader; SV_Gnt = OUT_Gnt = 0.
  - Every LD_WE is issued; the loader is never stalled.
- SOLVE: SV_Req and OUT_Req arbitrated round-robin.
  - If only one requests, it wins.
  - If both request, the one the pointer selects wins, and the pointer moves to the other requester.
  - A lone winner also moves the pointer to the other requester.
  - Neither requester may wait more than 1 cycle while the other holds its request.
- UNLOAD: only the encoder.
- IDLE: no grants.
- A requester must hold Req/Address/Data stable until Gnt; a deasserted request is not remembered.

RAM command (registered, 1-cycle latency):
- A grant in cycle t drives RAM_En/RAM_WE/RAM_Address/RAM_WData at cycle t+1.
- With no grant, RAM_En=0 and RAM_WE=0; address and data hold their previous values.

Read return:
- RAM_RData is valid at t+2.
- A 1-bit owner tag travels with the read. SV_RValid or OUT_RValid pulses for exactly 1 cycle at t+2, with RData registered alongside.
- Writes never produce RValid.
- Back-to-back reads give one return per cycle, in issue order.
- RData holds its last value when RValid=0.

LD_Overrun:
- Set when LD_WE=1 while Mode != LOAD; that write is dropped (no RAM_En).
- Cleared only by RST.

Simultaneous events:
- When Done_Loading and Loading_Enable are both high in IDLE, only the IDLE->LOAD transition applies.
- On the transition cycle into SOLVE, grants still follow the old mode (LOAD).

Test Plan:
- Reset, then Loading_Enable=1 and LD_WE bursts of 5 consecutive writes to addresses 0..4, data 0xA0..0xA4 -> RAM_WE=1 on cycles t+1..t+5 with matching address/data; SV_Gnt=0 throughout even with SV_Req=1.
- In SOLVE, SV_Req and OUT_Req held high for 6 cycles -> grants alternate SV, OUT, SV, OUT, SV, OUT; solver reads addr 2507 returning 0x1234 -> SV_RValid at grant+2 with SV_RData=0x1234, OUT_RValid=0 that cycle.
- In SOLVE, only the solver requests, for 4 back-to-back reads -> SV_Gnt=1 every cycle; 4 consecutive SV_RValid pulses in order.
- In SOLVE, LD_WE=1 to addr 7 -> no RAM_En, LD_Overrun=1 and stays 1 until RST.
- Mode walk: Loading_Enable -> Done_Loading -> Solve_Done -> Unload_Done -> Mode goes 1, 2, 3, 0; OUT_Gnt=0 in LOAD, SV_Gnt=0 in UNLOAD.
- RST asserted one cycle after a granted solver read -> no SV_RValid, all outputs 0, Mode=IDLE the next cycle.

Source files
------------

// File: rtl/ram_port_scheduler.sv
// rtl/ram_port_scheduler.sv - single RAM port owner sequencing load, solve and unload access
module ram_port_scheduler #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Loading_Enable,
  input  logic                     Done_Loading,
  input  logic                     Solve_Done,
  input  logic                     Unload_Done,
  input  logic                     LD_WE,
  input  logic [ADDRESS_WIDTH-1:0] LD_Address,
  input  logic [DATA_WIDTH-1:0]    LD_Data,
  input  logic                     SV_Req,
  input  logic                     SV_WE,
  input  logic [ADDRESS_WIDTH-1:0] SV_Address,
  input  logic [DATA_WIDTH-1:0]    SV_WData,
  output logic                     SV_Gnt,
  output logic                     SV_RValid,
  output logic [DATA_WIDTH-1:0]    SV_RData,
  input  logic                     OUT_Req,
  input  logic [ADDRESS_WIDTH-1:0] OUT_Address,
  output logic                     OUT_Gnt,
  output logic                     OUT_RValid,
  output logic [DATA_WIDTH-1:0]    OUT_RData,
  output logic                     RAM_En,
  output logic                     RAM_WE,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address,
  output logic [DATA_WIDTH-1:0]    RAM_WData,
  input  logic [DATA_WIDTH-1:0]    RAM_RData,
  output logic [1:0]               Mode,
  output logic                     LD_Overrun
);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LOAD   = 2'd1,
    MODE_SOLVE  = 2'd2,
    MODE_UNLOAD = 2'd3
  } mode_e;

  mode_e                     mode_q, mode_d;
  logic                      rr_ptr_q, rr_ptr_d;  // 0: solver preferred, 1: encoder preferred
  logic                      ld_overrun_q, ld_overrun_d;
  logic                      ram_en_q, ram_en_d;
  logic                      ram_we_q, ram_we_d;
  logic [ADDRESS_WIDTH-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]     ram_wdata_q, ram_wdata_d;
  logic                      rd_pend_q, rd_pend_d;
  logic                      rd_owner_q, rd_owner_d;  // 1: encoder owns the read in flight
  logic                      sv_rvalid_q, sv_rvalid_d;
  logic                      out_rvalid_q, out_rvalid_d;
  logic [DATA_WIDTH-1:0]     sv_rdata_q, sv_rdata_d;
  logic [DATA_WIDTH-1:0]     out_rdata_q, out_rdata_d;

  logic ld_issue;
  logic sv_gnt;
  logic out_gnt;

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_IDLE:   if (Loading_Enable) mode_d = MODE_LOAD;
      MODE_LOAD:   if (Done_Loading)   mode_d = MODE_SOLVE;
      MODE_SOLVE:  if (Solve_Done)     mode_d = MODE_UNLOAD;
      MODE_UNLOAD: if (Unload_Done)    mode_d = MODE_IDLE;
      default:     mode_d = MODE_IDLE;
    endcase
  end

  always_comb begin
    ld_issue = 1'b0;
    sv_gnt   = 1'b0;
    out_gnt  = 1'b0;
    rr_ptr_d = rr_ptr_q;
    case (mode_q)
      MODE_LOAD: ld_issue = LD_WE;
      MODE_SOLVE: begin
        if (SV_Req && (!OUT_Req || !rr_ptr_q)) begin
          sv_gnt   = 1'b1;
          rr_ptr_d = 1'b1;
        end else if (OUT_Req) begin
          out_gnt  = 1'b1;
          rr_ptr_d = 1'b0;
        end
      end
      MODE_UNLOAD: out_gnt = OUT_Req;
      default: ;
    endcase
  end

  always_comb begin
    ld_overrun_d = ld_overrun_q | (LD_WE & (mode_q != MODE_LOAD));
    ram_en_d     = ld_issue | sv_gnt | out_gnt;
    ram_we_d     = ld_issue | (sv_gnt & SV_WE);
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    if (ld_issue) begin
      ram_addr_d  = LD_Address;
      ram_wdata_d = LD_Data;
    end else if (sv_gnt) begin
      ram_addr_d = SV_Address;
      if (SV_WE) ram_wdata_d = SV_WData;
    end else if (out_gnt) begin
      ram_addr_d = OUT_Address;
    end
  end

  // Read tag pipeline: stage 1 rides with the RAM command, stage 2 marks when RAM_RData is valid.
  always_comb begin
    rd_pend_d    = (sv_gnt & ~SV_WE) | out_gnt;
    rd_owner_d   = out_gnt;
    sv_rvalid_d  = rd_pend_q & ~rd_owner_q;
    out_rvalid_d = rd_pend_q & rd_owner_q;
    sv_rdata_d   = sv_rvalid_q  ? RAM_RData : sv_rdata_q;
    out_rdata_d  = out_rvalid_q ? RAM_RData : out_rdata_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q       <= MODE_IDLE;
      rr_ptr_q     <= 1'b0;
      ld_overrun_q <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      sv_rvalid_q  <= 1'b0;
      out_rvalid_q <= 1'b0;
      sv_rdata_q   <= '0;
      out_rdata_q  <= '0;
    end else begin
      mode_q       <= mode_d;
      rr_ptr_q     <= rr_ptr_d;
      ld_overrun_q <= ld_overrun_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      sv_rvalid_q  <= sv_rvalid_d;
      out_rvalid_q <= out_rvalid_d;
      sv_rdata_q   <= sv_rdata_d;
      out_rdata_q  <= out_rdata_d;
    end
  end

  // RAM data only exists in the return cycle, so it is forwarded then and held in _q afterwards.
  assign SV_RData    = sv_rvalid_q  ? RAM_RData : sv_rdata_q;
  assign OUT_RData   = out_rvalid_q ? RAM_RData : out_rdata_q;
  assign SV_RValid   = sv_rvalid_q;
  assign OUT_RValid  = out_rvalid_q;
  assign SV_Gnt      = sv_gnt;
  assign OUT_Gnt     = out_gnt;
  assign RAM_En      = ram_en_q;
  assign RAM_WE      = ram_we_q;
  assign RAM_Address = ram_addr_q;
  assign RAM_WData   = ram_wdata_q;
  assign Mode        = mode_q;
  assign LD_Overrun  = ld_overrun_q;

endmodule

// File: tb/tb_ram_port_scheduler.sv
// tb/tb_ram_port_scheduler.sv - randomized scoreboard bench for ram_port_scheduler
module tb_ram_port_scheduler;

  localparam int AW = 13;
  localparam int DW = 64;
  localparam int M_IDLE = 0, M_LOAD = 1, M_SOLVE = 2, M_UNLOAD = 3;

  logic          CLK, RST;
  logic          Loading_Enable, Done_Loading, Solve_Done, Unload_Done;
  logic          LD_WE;
  logic [AW-1:0] LD_Address;
  logic [DW-1:0] LD_Data;
  logic          SV_Req, SV_WE;
  logic [AW-1:0] SV_Address;
  logic [DW-1:0] SV_WData;
  logic          SV_Gnt, SV_RValid;
  logic [DW-1:0] SV_RData;
  logic          OUT_Req;
  logic [AW-1:0] OUT_Address;
  logic          OUT_Gnt, OUT_RValid;
  logic [DW-1:0] OUT_RData;
  logic          RAM_En, RAM_WE;
  logic [AW-1:0] RAM_Address;
  logic [DW-1:0] RAM_WData;
  logic [DW-1:0] RAM_RData;
  logic [1:0]    Mode;
  logic          LD_Overrun;

  ram_port_scheduler dut (
    .CLK(CLK), .RST(RST),
    .Loading_Enable(Loading_Enable), .Done_Loading(Done_Loading),
    .Solve_Done(Solve_Done), .Unload_Done(Unload_Done),
    .LD_WE(LD_WE), .LD_Address(LD_Address), .LD_Data(LD_Data),
    .SV_Req(SV_Req), .SV_WE(SV_WE), .SV_Address(SV_Address), .SV_WData(SV_WData),
    .SV_Gnt(SV_Gnt), .SV_RValid(SV_RValid), .SV_RData(SV_RData),
    .OUT_Req(OUT_Req), .OUT_Address(OUT_Address),
    .OUT_Gnt(OUT_Gnt), .OUT_RValid(OUT_RValid), .OUT_RData(OUT_RData),
    .RAM_En(RAM_En), .RAM_WE(RAM_WE), .RAM_Address(RAM_Address),
    .RAM_WData(RAM_WData), .RAM_RData(RAM_RData),
    .Mode(Mode), .LD_Overrun(LD_Overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Synchronous-read RAM attached to the port
  bit [DW-1:0] mem [0:8191];
  initial RAM_RData = '0;
  always @(posedge CLK) begin
    if (RAM_En === 1'b1) begin
      if (RAM_WE === 1'b1) mem[RAM_Address] <= RAM_WData;
      else RAM_RData <= mem[RAM_Address];
    end
  end

  typedef struct {int cyc; bit we; logic [AW-1:0] addr; logic [DW-1:0] data;} cmd_t;
  typedef struct {int cyc; bit owner; logic [DW-1:0] data;} rd_t;
  typedef struct {int cyc; bit known; bit rst_prev; logic [1:0] mode; bit ovr; bit sv_gnt; bit out_gnt;} st_t;

  cmd_t cmd_q[$];
  rd_t  rd_q[$];
  st_t  st_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model state
  int          m_mode = M_IDLE;
  bit          m_ovr = 0, m_sv_turn = 1, m_known = 0, m_rst_prev = 0;
  bit          m_sv_g, m_out_g;
  bit [DW-1:0] ref_mem [int];

  function automatic bit [DW-1:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic model_step();
    bit sv_g, out_g, ld_w;
    sv_g = 0; out_g = 0; ld_w = 0;
    if (m_mode == M_LOAD) ld_w = LD_WE;
    else if (m_mode == M_SOLVE) begin
      if (SV_Req && OUT_Req) begin
        sv_g = m_sv_turn;
        out_g = !m_sv_turn;
      end else begin
        sv_g = SV_Req;
        out_g = OUT_Req;
      end
    end else if (m_mode == M_UNLOAD) out_g = OUT_Req;
    m_sv_g = sv_g;
    m_out_g = out_g;
    st_q.push_back('{cyc, m_known, m_rst_prev, 2'(m_mode), m_ovr, sv_g, out_g});
    if (RST) begin
      for (int i = cmd_q.size() - 1; i >= 0; i--) if (cmd_q[i].cyc > cyc) cmd_q.delete(i);
      for (int i = rd_q.size() - 1; i >= 0; i--) if (rd_q[i].cyc > cyc) rd_q.delete(i);
      m_mode = M_IDLE; m_ovr = 0; m_sv_turn = 1; m_known = 1; m_rst_prev = 1;
      return;
    end
    m_rst_prev = 0;
    if (ld_w) begin
      cmd_q.push_back('{cyc + 1, 1'b1, LD_Address, LD_Data});
      ref_mem[int'(LD_Address)] = LD_Data;
    end else if (sv_g) begin
      if (SV_WE) begin
        cmd_q.push_back('{cyc + 1, 1'b1, SV_Address, SV_WData});
        ref_mem[int'(SV_Address)] = SV_WData;
      end else begin
        cmd_q.push_back('{cyc + 1, 1'b0, SV_Address, '0});
        rd_q.push_back('{cyc + 2, 1'b0, ref_read(int'(SV_Address))});
      end
    end else if (out_g) begin
      cmd_q.push_back('{cyc + 1, 1'b0, OUT_Address, '0});
      rd_q.push_back('{cyc + 2, 1'b1, ref_read(int'(OUT_Address))});
    end
    if (m_mode == M_SOLVE && (sv_g || out_g)) m_sv_turn = out_g;
    if (LD_WE && m_mode != M_LOAD) m_ovr = 1;
    case (m_mode)
      M_IDLE:   if (Loading_Enable) m_mode = M_LOAD;
      M_LOAD:   if (Done_Loading)   m_mode = M_SOLVE;
      M_SOLVE:  if (Solve_Done)     m_mode = M_UNLOAD;
      default:  if (Unload_Done)    m_mode = M_IDLE;
    endcase
  endtask

  // Requester generators
  int sv_rate = 0, out_rate = 0, sv_wr = 0;

  function automatic logic [AW-1:0] rand_addr();
    int k;
    k = $urandom_range(16);
    return (k == 16) ? AW'(2507) : AW'(k);
  endfunction

  task automatic gen_reqs();
    if (!SV_Req && $urandom_range(99) < sv_rate) begin
      SV_Req = 1; SV_WE = ($urandom_range(99) < sv_wr);
      SV_Address = rand_addr(); SV_WData = {$urandom, $urandom};
    end
    if (!OUT_Req && $urandom_range(99) < out_rate) begin
      OUT_Req = 1; OUT_Address = rand_addr();
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK); #1;
    if (m_sv_g) SV_Req = 0;
    if (m_out_g) OUT_Req = 0;
    LD_WE = 0; Done_Loading = 0; Solve_Done = 0; Unload_Done = 0; Loading_Enable = 0;
    gen_reqs();
  endtask

  // Monitor: pops expectations and compares against what the DUT presents
  st_t s;
  cmd_t c;
  rd_t r;
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_sv = '0, h_out = '0;

  always @(negedge CLK) begin
    while (st_q.size() > 0 && st_q[0].cyc < cyc) void'(st_q.pop_front());
    if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
      s = st_q.pop_front();
      if (s.known) begin
        if (s.rst_prev) begin
          h_addr = '0; h_sv = '0; h_out = '0;
          chk("wdata_after_reset", RAM_WData, '0);
        end
        chk("mode", Mode, s.mode);
        chk("ld_overrun", LD_Overrun, s.ovr);
        chk("sv_gnt", SV_Gnt, s.sv_gnt);
        chk("out_gnt", OUT_Gnt, s.out_gnt);
        while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
          c = cmd_q.pop_front();
          chk("cmd_issue_cycle", cyc, c.cyc);
        end
        if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
          c = cmd_q.pop_front();
          chk("ram_en", RAM_En, 1);
          chk("ram_we", RAM_WE, c.we);
          chk("ram_addr", RAM_Address, c.addr);
          if (c.we) chk("ram_wdata", RAM_WData, c.data);
          h_addr = c.addr;
        end else begin
          chk("ram_en_idle", RAM_En, 0);
          chk("ram_we_idle", RAM_WE, 0);
          chk("ram_addr_hold", RAM_Address, h_addr);
        end
        while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
          r = rd_q.pop_front();
          chk("rd_return_cycle", cyc, r.cyc);
        end
        if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
          r = rd_q.pop_front();
          chk("sv_rvalid", SV_RValid, !r.owner);
          chk("out_rvalid", OUT_RValid, r.owner);
          if (r.owner) h_out = r.data;
          else h_sv = r.data;
        end else begin
          chk("sv_rvalid_idle", SV_RValid, 0);
          chk("out_rvalid_idle", OUT_RValid, 0);
        end
        chk("sv_rdata", SV_RData, h_sv);
        chk("out_rdata", OUT_RData, h_out);
      end
    end
  end

  initial begin
    RST = 1; Loading_Enable = 0; Done_Loading = 0; Solve_Done = 0; Unload_Done = 0;
    LD_WE = 0; LD_Address = '0; LD_Data = '0;
    SV_Req = 0; SV_WE = 0; SV_Address = '0; SV_WData = '0;
    OUT_Req = 0; OUT_Address = '0;
    @(posedge CLK); #1;
    tick(); tick();
    RST = 0;
    tick();
    // Done_Loading together with Loading_Enable in IDLE only enters LOAD
    Loading_Enable = 1; Done_Loading = 1;
    tick();
    sv_rate = 100; sv_wr = 50;
    for (int i = 0; i < 5; i++) begin
      LD_WE = 1; LD_Address = AW'(i); LD_Data = 64'hA0 + 64'(i);
      tick();
    end
    LD_WE = 1; LD_Address = AW'(2507); LD_Data = 64'h1234;
    tick();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(99) < 70) begin
        LD_WE = 1; LD_Address = AW'($urandom_range(15)); LD_Data = {$urandom, $urandom};
      end
      tick();
    end
    LD_WE = 1; LD_Address = AW'(15); LD_Data = 64'hF00D; Done_Loading = 1;
    tick();
    // SOLVE: both requesters held high
    SV_Req = 1; SV_WE = 0; SV_Address = AW'(2507);
    OUT_Req = 1; OUT_Address = AW'(3);
    sv_rate = 100; out_rate = 100; sv_wr = 0;
    for (int i = 0; i < 6; i++) tick();
    out_rate = 0;
    for (int i = 0; i < 4 && OUT_Req; i++) tick();
    for (int i = 0; i < 4; i++) tick();
    LD_WE = 1; LD_Address = AW'(7); LD_Data = 64'hDEAD;
    tick();
    sv_rate = 60; out_rate = 50; sv_wr = 40;
    for (int i = 0; i < 300; i++) begin
      if (i == 100) Unload_Done = 1;
      if (i == 150) begin Done_Loading = 1; Loading_Enable = 1; end
      tick();
    end
    Solve_Done = 1;
    tick();
    out_rate = 60;
    for (int i = 0; i < 60; i++) tick();
    Unload_Done = 1;
    tick();
    sv_rate = 50; out_rate = 50;
    for (int i = 0; i < 5; i++) tick();
    // Second run ending with a reset right after a granted solver read
    sv_rate = 0; out_rate = 0; SV_Req = 0; OUT_Req = 0;
    Loading_Enable = 1;
    tick();
    LD_WE = 1; LD_Address = AW'(2); LD_Data = 64'hBEEF;
    tick();
    Done_Loading = 1;
    tick();
    SV_Req = 1; SV_WE = 0; SV_Address = AW'(2);
    tick();
    RST = 1;
    tick();
    RST = 0; SV_Req = 0; OUT_Req = 0;
    for (int i = 0; i < 6; i++) tick();
    @(negedge CLK); #1;
    chk("cmd_queue_drained", 64'(cmd_q.size()), 0);
    chk("rd_queue_drained", 64'(rd_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
